// File: rtl/cam_table_reader.sv
// cam_table_reader: walks a sorted CAM from index 0 and streams qualifying entries over valid/ready
module cam_table_reader #(
  parameter int NUM_ENTRY  = 25,
  parameter int INDEX_SIZE = $clog2(NUM_ENTRY),
  parameter int ADDR_SIZE  = 22,
  parameter int CNT_SIZE   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_SIZE-1:0]   threshold,
  input  logic                  clear_on_read,
  output logic                  busy,
  output logic                  done,
  output logic [INDEX_SIZE:0]   num_emitted,
  output logic                  cam_hold,
  output logic                  cam_rd_en,
  output logic [INDEX_SIZE-1:0] cam_rd_idx,
  input  logic [ADDR_SIZE-1:0]  cam_rd_addr,
  input  logic [CNT_SIZE-1:0]   cam_rd_cnt,
  output logic                  cam_clr_en,
  output logic [INDEX_SIZE-1:0] cam_clr_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_SIZE-1:0]  out_addr,
  output logic [CNT_SIZE-1:0]   out_cnt,
  output logic [INDEX_SIZE-1:0] out_idx
);
  typedef enum logic [2:0] {IDLE, REQ, RESP, OUT, CLR, DONE} state_t;
  state_t state;
  logic [CNT_SIZE-1:0] thr;
  logic clr;
  logic [INDEX_SIZE-1:0] idx;
  logic [INDEX_SIZE-1:0] nxt;
  logic last;
  assign nxt = idx + INDEX_SIZE'(1);
  assign last = idx == INDEX_SIZE'(NUM_ENTRY - 1);
  assign busy = state != IDLE;
  assign cam_hold = busy;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      thr <= '0;
      clr <= 1'b0;
      idx <= '0;
      done <= 1'b0;
      num_emitted <= '0;
      cam_rd_en <= 1'b0;
      cam_rd_idx <= '0;
      cam_clr_en <= 1'b0;
      cam_clr_idx <= '0;
      out_valid <= 1'b0;
      out_addr <= '0;
      out_cnt <= '0;
      out_idx <= '0;
    end else begin
      cam_rd_en <= 1'b0;
      cam_clr_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          thr <= threshold;
          clr <= clear_on_read;
          idx <= '0;
          num_emitted <= '0;
          cam_rd_en <= 1'b1;
          cam_rd_idx <= '0;
          state <= REQ;
        end
        REQ: state <= RESP;
        RESP: begin
          out_addr <= cam_rd_addr;
          out_cnt <= cam_rd_cnt;
          out_idx <= idx;
          // table is sorted descending, so the first miss ends the scan
          if (cam_rd_cnt != '0 && cam_rd_cnt >= thr) begin
            out_valid <= 1'b1;
            state <= OUT;
          end else begin
            done <= 1'b1;
            state <= DONE;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          num_emitted <= num_emitted + (INDEX_SIZE+1)'(1);
          if (clr) begin
            cam_clr_en <= 1'b1;
            cam_clr_idx <= idx;
            state <= CLR;
          end else if (last) begin
            done <= 1'b1;
            state <= DONE;
          end else begin
            idx <= nxt;
            cam_rd_en <= 1'b1;
            cam_rd_idx <= nxt;
            state <= REQ;
          end
        end
        CLR: if (last) begin
          done <= 1'b1;
          state <= DONE;
        end else begin
          idx <= nxt;
          cam_rd_en <= 1'b1;
          cam_rd_idx <= nxt;
          state <= REQ;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
